wave_graph: RTL
===============

Name: wave_graph

Overview:
- Parametrised logic-analyser waveform renderer for the VGA controller.
- Captures a CHANNELS x CH_W probe word into a DEPTH-sample circular history on each sample strobe.
- Supports free-run and edge-triggered freeze.
- Renders the history as per-channel lanes (bit or vector style) from the pixel scan coordinates.
- rgb_out is ORed into the VGA pixel path; sync must be delayed by the fixed pipeline latency.

Parameters:
- CHANNELS, 10: number of probe lanes.
- CH_W, 2: bits per channel in state.
- DEPTH, 256: history samples; must be a power of two.
- AW, 8: log2(DEPTH).
- PIX_SHIFT, 2: each sample spans 2^PIX_SHIFT pixel columns.
- PY0, 10: top row of lane 0.
- PITCH, 30: vertical distance between lane tops.
- HEIGHT, 10: lane height in rows; must be at least 2.
- VEC_MASK, 10'b0011100000: bit i set means lane i renders in vector style.
- PRE, 64: pre-trigger samples kept; must satisfy 0 < PRE < DEPTH.
- TW, 4: width of trig_ch; at least log2(CHANNELS).

Ports:
- clk, input, 1: pixel/system clock.
- rst, input, 1: reset.
- sample_stb, input, 1: capture state this cycle.
- state, input, CHANNELS*CH_W: probe word; channel i is state[i*CH_W +: CH_W].
- run, input, 1: pulse; return to free-run.
- arm, input, 1: pulse; arm trigger.
- trig_ch, input, TW: channel whose bit 0 is the trigger source.
- trig_edge, input, 1: 1 = rising, 0 = falling.
- x, input, 11: pixel column.
- y, input, 10: pixel row.
- rgb_out, output, 3: pixel colour.
- trig_state, output, 2: 0 IDLE, 1 ARMED, 2 POST, 3 FROZEN.
- fill, output, AW+1: valid samples held, saturating at DEPTH.

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - rgb_out = 0, trig_state = IDLE, fill = 0.
  - wr_ptr = 0, post_cnt = 0, prev_trig_bit = 0, all pipeline registers = 0.
  - Buffer RAM is not reset.
- Capture:
  - When sample_stb is high and trig_state != FROZEN: write state to mem[wr_ptr], wr_ptr increments mod DEPTH, fill saturates at DEPTH.
  - prev_trig_bit is loaded with the selected bit on every accepted strobe.
- Trigger state machine:
  - Any state: run=1 moves to IDLE. run wins over a simultaneous arm.
  - Any state: arm=1 (without run) moves to ARMED and clears post_cnt. No trigger is evaluated in the arm cycle.
  - ARMED: on an accepted strobe where prev_trig_bit to the new bit matches trig_edge (0->1 or 1->0), move to POST with post_cnt = 1. The trigger sample itself is written.
  - POST: each accepted strobe increments post_cnt. When post_cnt reaches DEPTH-PRE, move to FROZEN in that same cycle.
  - FROZEN: strobes are ignored; hold until run or arm.
  - A trigger before fill >= PRE is legal; the earlier columns show blank.
- Display window:
  - base = wr_ptr when fill == DEPTH, otherwise 0.
  - Column c = x >> PIX_SHIFT.
  - Read address = (base + c) mod DEPTH.
  - Column c is valid iff c < fill and c < DEPTH.
- Lane hit: lane i is hit when PY0 + i*PITCH <= y < PY0 + i*PITCH + HEIGHT, using parallel comparators with priority to the lowest i. Top row = first lane row; bottom row = last lane row.
- Pipeline, latency 2 (rgb_out at cycle t+2 reflects x,y presented at t):
  - Stage 1: register lane index, top/bottom flags, column, column-start flag (low PIX_SHIFT bits of x == 0), and valid. Issue the synchronous RAM read.
  - Stage 2: RAM word available; compute rgb_out.
- Edge detection:
  - prev_word holds the previous column's word. It loads on the stage-2 column-start pixel and is invalidated when x == 0.
  - A change at column start = selected channel differs from prev_word with prev valid. Column 0 never shows a change.
- Colours:
  - Bit lane: 3'b010 on the top row if bit 0 = 1, on the bottom row if bit 0 = 0. On a change at column start, 3'b010 on all lane rows.
  - Vector lane: 3'b011 on top and bottom rows. On a change at column start, 3'b111 on all lane rows.
  - FROZEN cursor: column PRE, first pixel, over any lane row, 3'b100. The cursor overrides waveform colour.
  - Otherwise 0; invalid columns and no lane hit give 0.
- Read/write collision on the same address in the same cycle returns old data (read-before-write).

Decomposition:
- Shared package holds:
  - trigger-state encodings IDLE/ARMED/POST/FROZEN;
  - colour constants COL_BIT, COL_VEC, COL_EDGE, COL_CUR;
  - a clog2 function.
- One sub-module, wave_graph_ram: simple dual-port, DEPTH x CHANNELS*CH_W, registered read, no reset.

Test Plan:
- Reset mid-POST (rst pulse while trig_state=2, fill=100) -> trig_state=0, fill=0, rgb_out=0 next cycle, all lanes blank.
- Free-run, 3 strobes of lane0 bit pattern 1,0,1; scan y=10, x=0..11 -> rgb_out 3'b010 at x=0..3 and 8..11 (2-cycle delay); at y=19, x=5..7 only; x=4 and x=8 full-lane 3'b010 edges.
- Fill 256 strobes, arm, trig_ch=0 rising, trig_edge=1, drive 0 then 1 -> POST after the edge, FROZEN after exactly 192 strobes including the trigger; further strobes leave fill=256 and wr_ptr unchanged; cursor 3'b100 at x=256.
- arm and run asserted in the same cycle while FROZEN -> trig_state=IDLE; capture resumes on the next strobe.
- Vector lane 5 (y=160), values 2,2,3 -> 3'b011 on rows 160 and 169; 3'b111 full height only at x=8.
- fill=5, scan x=20 on any lane row -> rgb_out=0 (column 5 invalid); x>=1024 -> 0.

Source files
------------

// File: rtl/wave_graph_pkg.sv
// Shared types and constants for the logic-analyser waveform renderer.
package wave_graph_pkg;

  // Trigger state machine encodings (also driven out on trig_state).
  typedef enum logic [1:0] {
    TS_IDLE   = 2'd0,
    TS_ARMED  = 2'd1,
    TS_POST   = 2'd2,
    TS_FROZEN = 2'd3
  } trig_state_t;

  // Pixel colours, ORed into the VGA pixel path by the integrator.
  localparam logic [2:0] COL_OFF  = 3'b000;
  localparam logic [2:0] COL_BIT  = 3'b010;
  localparam logic [2:0] COL_VEC  = 3'b011;
  localparam logic [2:0] COL_EDGE = 3'b111;
  localparam logic [2:0] COL_CUR  = 3'b100;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wave_graph_ram.sv
// Simple dual-port history RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module wave_graph_ram
  import wave_graph_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write and registered read share a clock; NBA ordering gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/wave_graph.sv
// Waveform renderer: captures probe words into a circular history, runs an
// edge trigger with pre-trigger window, and draws per-channel lanes from the
// pixel scan position with a fixed two-cycle latency (x,y at t -> rgb_out at t+2).
//
// Capture qualifier: sample_stb is a single-cycle strobe with no back-pressure;
// a strobe is accepted in any cycle where the trigger state is not FROZEN, and
// the word on state is written in that same cycle.
module wave_graph
  import wave_graph_pkg::*;
#(
  parameter int                  CHANNELS  = 10,
  parameter int                  CH_W      = 2,
  parameter int                  DEPTH     = 256,
  parameter int                  AW        = 8,
  parameter int                  PIX_SHIFT = 2,
  parameter int                  PY0       = 10,
  parameter int                  PITCH     = 30,
  parameter int                  HEIGHT    = 10,
  parameter logic [CHANNELS-1:0] VEC_MASK  = 10'b0011100000,
  parameter int                  PRE       = 64,
  parameter int                  TW        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_stb,
  input  logic [CHANNELS*CH_W-1:0] state,
  input  logic                     run,
  input  logic                     arm,
  input  logic [TW-1:0]            trig_ch,
  input  logic                     trig_edge,
  input  logic [10:0]              x,
  input  logic [9:0]               y,
  output logic [2:0]               rgb_out,
  output logic [1:0]               trig_state,
  output logic [AW:0]              fill
);

  localparam int SW = CHANNELS * CH_W;
  localparam int LW = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS);
  localparam int CW = 11 - PIX_SHIFT;
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   POST_N   = (AW+1)'(DEPTH - PRE);
  localparam logic [CW-1:0] CUR_COL  = CW'(PRE);
  localparam logic [10:0]   LOW_MASK = 11'((1 << PIX_SHIFT) - 1);

  // ---------------------------------------------------------------- capture
  trig_state_t   state_q, state_d;
  logic [AW:0]   post_cnt_q, post_cnt_d;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   fill_q;
  logic          prev_trig_bit;
  logic          accept;
  logic          sel_bit;
  logic          trig_hit;

  assign accept = sample_stb && (state_q != TS_FROZEN);

  // Pick bit 0 of the selected trigger channel; out-of-range channels read 0.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(trig_ch) == i) sel_bit = state[i*CH_W];
    end
  end

  assign trig_hit = accept && (trig_edge ? (!prev_trig_bit && sel_bit)
                                         : (prev_trig_bit && !sel_bit));

  // Write pointer, saturating fill count and last trigger bit advance per accepted strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      fill_q        <= '0;
      prev_trig_bit <= 1'b0;
    end else if (accept) begin
      wr_ptr        <= wr_ptr + AW'(1);
      prev_trig_bit <= sel_bit;
      if (fill_q != FULL) fill_q <= fill_q + (AW+1)'(1);
    end
  end

  // ---------------------------------------------------------------- trigger FSM
  // Trigger state and post-trigger sample count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TS_IDLE;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  // Next state: run beats arm; arm restarts the hunt; POST counts to the freeze point.
  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    if (run) begin
      state_d = TS_IDLE;
    end else if (arm) begin
      state_d    = TS_ARMED;
      post_cnt_d = '0;
    end else begin
      case (state_q)
        TS_ARMED: begin
          if (trig_hit) begin
            post_cnt_d = (AW+1)'(1);
            state_d    = (post_cnt_d == POST_N) ? TS_FROZEN : TS_POST;
          end
        end
        TS_POST: begin
          if (accept) begin
            post_cnt_d = post_cnt_q + (AW+1)'(1);
            if (post_cnt_d == POST_N) state_d = TS_FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

  assign trig_state = state_q;
  assign fill       = fill_q;

  // ---------------------------------------------------------------- render front end
  logic [CW-1:0] col;
  logic          col_start;
  logic          col_valid;
  logic [AW-1:0] base;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_word;
  int            y_int;
  logic          lane_hit;
  logic [LW-1:0] lane_idx;
  logic          lane_top;
  logic          lane_bot;

  assign col       = CW'(x >> PIX_SHIFT);
  assign col_start = (x & LOW_MASK) == 11'd0;
  assign col_valid = (int'(col) < int'(fill_q)) && (int'(col) < DEPTH);
  // Once the buffer has wrapped, the oldest sample sits at the write pointer.
  assign base      = (fill_q == FULL) ? wr_ptr : '0;
  assign rd_addr   = base + AW'(col);
  assign y_int     = int'({22'd0, y});

  // Parallel lane comparators; scanning high-to-low leaves the lowest lane winning.
  always_comb begin
    lane_hit = 1'b0;
    lane_idx = '0;
    lane_top = 1'b0;
    lane_bot = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (y_int >= PY0 + i*PITCH && y_int < PY0 + i*PITCH + HEIGHT) begin
        lane_hit = 1'b1;
        lane_idx = LW'(i);
        lane_top = (y_int == PY0 + i*PITCH);
        lane_bot = (y_int == PY0 + i*PITCH + HEIGHT - 1);
      end
    end
  end

  wave_graph_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (SW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (state),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // ---------------------------------------------------------------- stage 1
  logic          s1_hit, s1_top, s1_bot, s1_cstart, s1_valid, s1_x0, s1_frozen;
  logic [LW-1:0] s1_lane;
  logic [CW-1:0] s1_col;

  // Stage 1 holds the pixel context alongside the RAM read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hit    <= 1'b0;
      s1_top    <= 1'b0;
      s1_bot    <= 1'b0;
      s1_cstart <= 1'b0;
      s1_valid  <= 1'b0;
      s1_x0     <= 1'b0;
      s1_frozen <= 1'b0;
      s1_lane   <= '0;
      s1_col    <= '0;
    end else begin
      s1_hit    <= lane_hit;
      s1_top    <= lane_top;
      s1_bot    <= lane_bot;
      s1_cstart <= col_start;
      s1_valid  <= col_valid;
      s1_x0     <= (x == 11'd0);
      s1_frozen <= (state_q == TS_FROZEN);
      s1_lane   <= lane_idx;
      s1_col    <= col;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [SW-1:0]   prev_word;
  logic            prev_valid;
  logic            prev_ok;
  logic [CH_W-1:0] cur_ch, prv_ch;
  logic            is_vec;
  logic            change;
  logic [2:0]      pix;

  // Slice the lane's channel out of the current and previous column words.
  always_comb begin
    cur_ch = '0;
    prv_ch = '0;
    is_vec = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(s1_lane) == i) begin
        cur_ch = rd_word[i*CH_W +: CH_W];
        prv_ch = prev_word[i*CH_W +: CH_W];
        is_vec = VEC_MASK[i];
      end
    end
  end

  // Column 0 starts a fresh line, so the previous word is never trusted there.
  assign prev_ok = prev_valid && !s1_x0;
  assign change  = s1_cstart && s1_valid && prev_ok && (cur_ch != prv_ch);

  // Colour selection: the frozen cursor wins, then vector or bit lane drawing.
  always_comb begin
    pix = COL_OFF;
    if (s1_hit && s1_valid) begin
      if (s1_frozen && s1_cstart && s1_col == CUR_COL) begin
        pix = COL_CUR;
      end else if (is_vec) begin
        if (change)                 pix = COL_EDGE;
        else if (s1_top || s1_bot)  pix = COL_VEC;
      end else begin
        if (change || (s1_top && cur_ch[0]) || (s1_bot && !cur_ch[0])) pix = COL_BIT;
      end
    end
  end

  // Output colour register and previous-column word tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out    <= COL_OFF;
      prev_word  <= '0;
      prev_valid <= 1'b0;
    end else begin
      rgb_out <= pix;
      if (s1_cstart) begin
        prev_word  <= rd_word;
        prev_valid <= s1_valid;
      end
    end
  end

endmodule
